// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with synchronous flush; 1-cycle latency.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer (registered in_ready), else in_ready = out_ready | ~out_valid.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;

  // State encoding doubles as the held-entry count.
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_fire;

  assign w_accept  = in_valid & in_ready;
  assign w_fire    = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? r_main : BUBBLE;
  assign count     = r_state;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] ST_TWO = 2'd2;

  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic [1:0]       w_state_nxt;

  assign in_ready = r_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_fire)      w_state_nxt = ST_TWO;
        else if (!w_accept && w_fire) w_state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (w_fire) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= BUBBLE;
      r_skid      <= BUBBLE;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
      if (r_state == ST_TWO) begin
        if (w_fire) r_main <= r_skid;
      end else if (w_accept) begin
        // A simultaneous fire frees main, so the new payload bypasses skid.
        if (r_state == ST_EMPTY || w_fire) r_main <= in_data;
        else                               r_skid <= in_data;
      end
    end
  end
`else
  assign in_ready = out_ready | ~r_out_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main      <= BUBBLE;
    end else if (w_accept) begin
      r_state     <= ST_ONE;
      r_out_valid <= 1'b1;
      r_main      <= in_data;
    end else if (w_fire) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; covers both builds depending on PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int W = 96;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fire must deliver the oldest outstanding expected payload.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", out_data, '1);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("delivery", out_data, e);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'('h1234); out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_empty", W'(out_valid), W'(0));

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i); exp_q.push_back(W'(i));
      step();
      check("stream_valid", W'(out_valid), W'(1));
      check("stream_count", W'(count), W'(1));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_count", W'(count), W'(0));
    check("stream_drain_bubble", out_data, W'(0));

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure absorbed by skid
    in_valid = 1'b1; in_data = W'('h10); exp_q.push_back(W'('h10));
    step();
    out_ready = 1'b0; in_data = W'('h11); exp_q.push_back(W'('h11));
    step();
    check("bp_count_two", W'(count), W'(2));
    check("bp_in_ready_low", W'(in_ready), W'(0));
    in_data = W'('h12); exp_q.push_back(W'('h12));
    step();
    check("bp_hold_count", W'(count), W'(2));
    check("bp_hold_data", out_data, W'('h10));
    step();
    check("bp_hold_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    step();
    check("bp_release_count", W'(count), W'(1));
    check("bp_release_data", out_data, W'('h11));
    step();
    check("bp_last_data", out_data, W'('h12));
    in_valid = 1'b0;
    step();
    check("bp_drained", W'(count), W'(0));

    // Flush in TWO discards held and incoming payloads
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('hAA);
    step();
    in_data = W'('hBB);
    step();
    check("fl_count_two", W'(count), W'(2));
    flush = 1'b1; in_data = W'('hCC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", W'(out_valid), W'(0));
    check("fl_count", W'(count), W'(0));
    check("fl_out_data", out_data, W'(0));
    out_ready = 1'b1;
    step(); step();
    check("fl_stays_empty", W'(out_valid), W'(0));
`else
    // Combinational in_ready when full
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h77); exp_q.push_back(W'('h77));
    step();
    in_data = W'('h88); exp_q.push_back(W'('h88));
    #1;
    check("ns_full_in_ready", W'(in_ready), W'(0));
    step();
    check("ns_hold_data", out_data, W'('h77));
    check("ns_hold_count", W'(count), W'(1));
    out_ready = 1'b1;
    #1;
    check("ns_comb_in_ready", W'(in_ready), W'(1));
    step();
    check("ns_next_data", out_data, W'('h88));
    in_valid = 1'b0;
    step();
    check("ns_drained", W'(count), W'(0));
`endif

    // Flush coinciding with fire still delivers the held payload
    out_ready = 1'b1; in_valid = 1'b1; in_data = W'('h55); exp_q.push_back(W'('h55));
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("ff_count", W'(count), W'(0));
    check("ff_out_valid", W'(out_valid), W'(0));
    step();

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the five-stage MIPS core, replacing fixed enable-only inter-stage registers (F/D, D/E, E/M, M/W). Carries an arbitrary-width payload with a valid/ready handshake, a synchronous flush that injects a bubble, and an optional two-entry skid buffer. With the skid buffer, upstream `in_ready` is fully registered while throughput stays at one transfer per cycle.

## Interface
- `WIDTH`, default 96: payload width (PC, PC+4 and Instr = 3×32).
- `BUBBLE`, default 0: payload value presented when the stage holds nothing (all-zero = MIPS `nop`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous, active-high; discards all held entries.
- `in_valid`  in  1  upstream holds a valid payload.
- `in_ready`  out  1  stage accepts a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage presents a valid payload.
- `out_ready`  in  1  downstream accepts the payload this cycle.
- `out_data`  out  WIDTH  payload to downstream; equals `BUBBLE` when `out_valid`=0.
- `count`  out  2  number of held entries (0..2).

## Operation
- Accept: `in_valid & in_ready`. Fire: `out_valid & out_ready`.
- Storage: `main` register drives `out_data`. A `skid` register exists only when the skid buffer is compiled in.
- States (skid build):
  - EMPTY: count=0, `out_valid`=0, `in_ready`=1.
  - ONE: count=1, `out_valid`=1, `in_ready`=1.
  - TWO: count=2, `out_valid`=1, `in_ready`=0.
- Transitions when neither reset nor flush is active:
  - EMPTY: accept → ONE, `main`←`in_data`.
  - ONE: accept & fire → ONE, `main`←`in_data`.
  - ONE: accept only → TWO, `skid`←`in_data`.
  - ONE: fire only → EMPTY.
  - TWO: fire → ONE, `main`←`skid`. No accept is possible in TWO.
- Ordering is strict FIFO. No payload is duplicated or lost except by flush.
- Flush:
  - State → EMPTY; `main` and `skid` ← `BUBBLE`.
  - An accept on the same cycle is discarded, even though `in_ready` may read 1.
  - A fire on the same cycle is still a valid transfer to downstream.
- Reset has priority over flush and produces the same result as flush.
- Reset values: `out_valid`=0, `out_data`=`BUBBLE`, `count`=0, `in_ready`=1 (skid build) or 1 via the combinational equation below (non-skid build).
- `out_data` is forced to `BUBBLE` whenever `out_valid`=0, independent of `main` contents.
- `in_data` is never inspected beyond storage. Payload is opaque, with no width conversion.

## Timing
- Latency: payload accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N, for the cycle N+1.
- Throughput: one transfer per cycle sustained while `out_ready`=1.
- Skid build:
  - `in_ready` and `out_valid` are pure register outputs with no input→output combinational path.
  - A single `out_ready` deassertion is absorbed without loss.
- Non-skid build:
  - `in_ready = out_ready | ~out_valid` (combinational path from `out_ready`).
  - `out_valid` stays registered.
- `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.
- Legacy enable-style use (stall = `~out_ready`, `in_valid`=1 tied) reproduces the old F/D behaviour with one cycle of latency.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- Defined: two-entry skid buffer with the EMPTY/ONE/TWO FSM above, registered `in_ready`, and `count` range 0..2.
- Undefined:
  - Single `main` register, states EMPTY/ONE only, `count` range 0..1.
  - `in_ready` is the combinational equation above.
  - The `skid` register and its mux are not synthesised.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `in_valid`=1 and `in_data`=0x1234 → `out_valid`=0, `out_data`=0 (`BUBBLE`), `count`=0, nothing accepted.
- Streaming: present 0x01..0x08 back-to-back with `out_ready`=1 → outputs 0x01..0x08 on consecutive cycles, each one cycle after its accept, `count` stays 1.
- Backpressure (skid build):
  - Stream 0x10, 0x11, 0x12; drop `out_ready` for 3 cycles starting when 0x10 is on the output.
  - `count` reaches 2 and `in_ready`=0 the cycle after 0x11 is accepted.
  - 0x12 is held upstream, not accepted, until space frees.
  - After `out_ready` returns: 0x10, 0x11, 0x12 delivered in order, no duplicates.
- Flush: in state TWO holding 0xAA, 0xBB, assert `flush` with `in_valid`=1, `in_data`=0xCC → next cycle `out_valid`=0, `count`=0, `out_data`=0; 0xCC is never delivered.
- Flush with fire: in state ONE with `out_ready`=1 and `flush`=1 → the held payload counts as delivered that cycle, and the stage is EMPTY after the edge.
- Non-skid build: with `out_ready`=0 and the stage full, drive `in_valid`=1 → `in_ready`=0 in the same cycle. Raise `out_ready` → `in_ready`=1 combinationally in that cycle, and the new payload appears on the next cycle.
